mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache controller (I-side, read-only line fills) and the data-cache controller (D-side, line fills and write-backs).
- Sits between both Cache_Controller instances and the memory model. Serialises their block requests, forwards exactly one at a time, and routes the memory response back to the owning requester.
- D-side has fixed priority. A wait counter keeps the I-side from starving.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter_pick.sv | 46 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the I/D main-memory arbiter.
// Imported by the pick logic, the top level and the bench.
package mem_arb_def;

    localparam int ADDR_W_DEF   = 16;
    localparam int LINE_W_DEF   = 64;
    localparam int MAX_WAIT_DEF = 8;
    localparam int TIMEOUT_DEF  = 255;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        I_SIDE = 2'b01,
        D_SIDE = 2'b10
    } owner_t;

    typedef struct packed {
        logic                  valid;
        logic                  rw;
        logic [ADDR_W_DEF-1:0] addr;
        logic [LINE_W_DEF-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter in one bundle.
// slave: the arbiter itself; master: caches plus memory model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 64
);

    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              d_req_valid;
    logic              d_req_rw;
    logic [ADDR_W-1:0] d_req_addr;
    logic [LINE_W-1:0] d_req_wdata;
    logic              i_ready;
    logic [LINE_W-1:0] i_rdata;
    logic              d_ready;
    logic [LINE_W-1:0] d_rdata;
    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;
    logic [1:0]        owner;
    logic              timeout_err;

    modport slave (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_rw, d_req_addr, d_req_wdata,
        input  mem_ready, mem_rdata,
        output i_ready, i_rdata, d_ready, d_rdata,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
        output owner, timeout_err
    );

    modport master (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_rw, d_req_addr, d_req_wdata,
        output mem_ready, mem_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
        input  owner, timeout_err
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Winner selection between I and D requesters with an I-side
// starvation counter that overrides the fixed D priority.
module mem_arb_pick
    import mem_arb_def::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid_i,
    input  logic d_valid_i,
    input  logic in_busy_i_i,
    input  logic take_i_i,
    output logic pick_i_o,
    output logic pick_d_o
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt_q;
    logic [WW-1:0] wait_cnt_d;
    logic          starved;

    assign starved  = wait_cnt_q >= WW'(MAX_WAIT);
    assign pick_d_o = d_valid_i && !(i_valid_i && starved);
    assign pick_i_o = i_valid_i && !pick_d_o;

    // Counts every cycle the I-side is kept waiting; saturates.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (take_i_i) begin
            wait_cnt_d = '0;
        end else if (i_valid_i && !in_busy_i_i && !starved) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache fills and D-cache fills/write-backs onto one
// memory port and steers the completion back to the owner.
module mem_arbiter
    import mem_arb_def::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LINE_W   = LINE_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state_q;
    owner_t        owner_q;
    arb_req_t      req_q;
    logic [CW-1:0] busy_cnt_q;
    logic [CW-1:0] busy_cnt_d;
    logic          err_q;
    logic          err_d;
    logic          pick_i;
    logic          pick_d;
    logic          idle;
    logic          busy;

    assign idle = state_q == IDLE;
    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

    mem_arb_pick #(
        .MAX_WAIT(MAX_WAIT)
    ) u_pick (
        .clk        (clk),
        .rst        (rst),
        .i_valid_i  (bus.i_req_valid),
        .d_valid_i  (bus.d_req_valid),
        .in_busy_i_i(state_q == BUSY_I),
        .take_i_i   (idle && pick_i),
        .pick_i_o   (pick_i),
        .pick_d_o   (pick_d)
    );

    // Timeout only flags the problem; the transfer keeps waiting.
    always_comb begin
        busy_cnt_d = '0;
        err_d      = err_q;
        if (busy && !bus.mem_ready) begin
            busy_cnt_d = (busy_cnt_q == CW'(TIMEOUT)) ? busy_cnt_q
                                                      : busy_cnt_q + 1'b1;
            if (busy_cnt_d == CW'(TIMEOUT)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= NONE;
            req_q      <= '0;
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
            err_q      <= err_d;
            unique case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q     <= BUSY_D;
                        owner_q     <= D_SIDE;
                        req_q.valid <= 1'b1;
                        req_q.rw    <= bus.d_req_rw;
                        req_q.addr  <= bus.d_req_addr;
                        req_q.wdata <= bus.d_req_wdata;
                    end else if (pick_i) begin
                        state_q     <= BUSY_I;
                        owner_q     <= I_SIDE;
                        req_q.valid <= 1'b1;
                        req_q.rw    <= 1'b0;
                        req_q.addr  <= bus.i_req_addr;
                        req_q.wdata <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ready) begin
                        state_q <= DONE;
                        owner_q <= NONE;
                        req_q   <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_valid = req_q.valid;
    assign bus.mem_req_rw    = req_q.rw;
    assign bus.mem_req_addr  = req_q.addr;
    assign bus.mem_req_wdata = req_q.wdata;
    assign bus.owner         = owner_q;
    assign bus.timeout_err   = err_q;

    assign bus.i_ready = (state_q == BUSY_I) && bus.mem_ready;
    assign bus.d_ready = (state_q == BUSY_D) && bus.mem_ready;
    assign bus.i_rdata = bus.i_ready ? bus.mem_rdata : '0;
    assign bus.d_rdata = bus.d_ready ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic idle_inputs();
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = '0;
        bus.d_req_valid = 1'b0;
        bus.d_req_rw    = 1'b0;
        bus.d_req_addr  = '0;
        bus.d_req_wdata = '0;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [83:0]  got;
        logic [129:0] rgot;
        do_reset();
        #1;
        got = {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr,
               bus.mem_req_wdata, bus.owner};
        n_tests++;
        if (got !== 84'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        n_tests++;
        if (bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        rgot = {bus.i_ready, bus.i_rdata, bus.d_ready, bus.d_rdata};
        n_tests++;
        if (rgot !== 130'h0) begin
            n_fail++;
            $display("FAIL idle_mem_ready_ignored: got %h want 0", rgot);
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_i_fill();
        logic [83:0]  got;
        logic [129:0] rgot;
        int           pulses = 0;
        do_reset();
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 16'h0040;
        #1;
        n_tests++;
        if (bus.mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ifill_latency: got %b want 0", bus.mem_req_valid);
        end
        step();
        #1;
        got = {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr,
               bus.mem_req_wdata, bus.owner};
        n_tests++;
        if (got !== {1'b1, 1'b0, 16'h0040, 64'h0, 2'b01}) begin
            n_fail++;
            $display("FAIL ifill_req: got %h want %h", got,
                     {1'b1, 1'b0, 16'h0040, 64'h0, 2'b01});
        end
        pulses += int'(bus.i_ready);
        for (int k = 2; k <= 3; k++) begin
            step();
            #1;
            pulses += int'(bus.i_ready);
        end
        step();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h1111_2222_3333_4444;
        #1;
        rgot = {bus.i_ready, bus.i_rdata, bus.d_ready, bus.d_rdata};
        n_tests++;
        if (rgot !== {1'b1, 64'h1111_2222_3333_4444, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL ifill_resp: got %h", rgot);
        end
        pulses += int'(bus.i_ready);
        for (int k = 0; k < 3; k++) begin
            step();
            bus.mem_ready   = 1'b0;
            bus.i_req_valid = 1'b0;
            #1;
            pulses += int'(bus.i_ready);
            n_tests++;
            if ({bus.owner, bus.mem_req_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL ifill_release: owner %b valid %b want 00 0",
                         bus.owner, bus.mem_req_valid);
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL ifill_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        logic [83:0]  got;
        logic [129:0] rgot;
        logic [63:0]  r;
        do_reset();
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 16'h0010;
        bus.d_req_valid = 1'b1;
        bus.d_req_rw    = 1'b1;
        bus.d_req_addr  = 16'h0200;
        bus.d_req_wdata = {16{4'hA}};
        step();
        #1;
        got = {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr,
               bus.mem_req_wdata, bus.owner};
        n_tests++;
        if (got !== {1'b1, 1'b1, 16'h0200, {16{4'hA}}, 2'b10}) begin
            n_fail++;
            $display("FAIL simul_d_first: got %h", got);
        end
        step();
        r = {$urandom, $urandom};
        bus.mem_ready = 1'b1;
        bus.mem_rdata = r;
        #1;
        rgot = {bus.d_ready, bus.d_rdata, bus.i_ready, bus.i_rdata};
        n_tests++;
        if (rgot !== {1'b1, r, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL simul_d_resp: got %h", rgot);
        end
        step();
        bus.mem_ready   = 1'b0;
        bus.d_req_valid = 1'b0;
        step();
        step();
        #1;
        got = {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr,
               bus.mem_req_wdata, bus.owner};
        n_tests++;
        if (got !== {1'b1, 1'b0, 16'h0010, 64'h0, 2'b01}) begin
            n_fail++;
            $display("FAIL simul_i_next: got %h", got);
        end
        step();
        r = {$urandom, $urandom};
        bus.mem_ready = 1'b1;
        bus.mem_rdata = r;
        #1;
        rgot = {bus.i_ready, bus.i_rdata, bus.d_ready, bus.d_rdata};
        n_tests++;
        if (rgot !== {1'b1, r, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL simul_i_resp: got %h", rgot);
        end
        step();
        idle_inputs();
    endtask

    // D held valid throughout; memory answers on its 4th request cycle.
    // Each D transfer then keeps I waiting 6 cycles, so I wins on the
    // third arbitration, cycle 12 after the first one.
    task automatic test_starvation();
        int          d_served = 0;
        int          i_at     = -1;
        int          lat      = 0;
        logic [15:0] i_addr   = '0;
        do_reset();
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 16'h0123;
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 16'h0456;
        for (int c = 0; c < 60 && i_at < 0; c++) begin
            step();
            bus.mem_ready = 1'b0;
            lat = bus.mem_req_valid ? lat + 1 : 0;
            if (lat == 4) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = {$urandom, $urandom};
            end
            #1;
            d_served += int'(bus.d_ready);
            if (bus.mem_req_valid && bus.owner == 2'b01) begin
                i_at   = c;
                i_addr = bus.mem_req_addr;
            end
        end
        n_tests++;
        if (d_served != 2) begin
            n_fail++;
            $display("FAIL starve_d_count: got %0d want 2", d_served);
        end
        n_tests++;
        if (i_at != 12 || i_addr !== 16'h0123) begin
            n_fail++;
            $display("FAIL starve_i_grant: cycle %0d addr %h want 12 0123",
                     i_at, i_addr);
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_stale_valid();
        int issued = 0;
        do_reset();
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 16'h0077;
        step();
        step();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h5;
        #1;
        n_tests++;
        if (bus.d_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_first_ready: got %b want 1", bus.d_ready);
        end
        step();
        bus.mem_ready = 1'b0;
        #1;
        issued += int'(bus.mem_req_valid);
        step();
        bus.d_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            issued += int'(bus.mem_req_valid) + int'(bus.d_ready);
            step();
        end
        n_tests++;
        if (issued != 0) begin
            n_fail++;
            $display("FAIL stale_duplicate: got %0d extra want 0", issued);
        end
    endtask

    task automatic test_timeout();
        logic [63:0]  r;
        logic [129:0] rgot;
        do_reset();
        bus.d_req_valid = 1'b1;
        bus.d_req_rw    = 1'b1;
        bus.d_req_addr  = 16'h0300;
        bus.d_req_wdata = {$urandom, $urandom};
        for (int n = 1; n <= 300; n++) begin
            step();
            #1;
            if (n == 255) begin
                n_tests++;
                if (bus.timeout_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_early: got %b want 0",
                             bus.timeout_err);
                end
            end
            if (n == 256) begin
                n_tests++;
                if (bus.timeout_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_set: got %b want 1",
                             bus.timeout_err);
                end
            end
        end
        step();
        r = {$urandom, $urandom};
        bus.mem_ready = 1'b1;
        bus.mem_rdata = r;
        #1;
        rgot = {bus.d_ready, bus.d_rdata, bus.i_ready, bus.i_rdata};
        n_tests++;
        if (rgot !== {1'b1, r, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL timeout_late_done: got %h", rgot);
        end
        step();
        idle_inputs();
        step();
        step();
        #1;
        n_tests++;
        if ({bus.timeout_err, bus.owner} !== 3'b100) begin
            n_fail++;
            $display("FAIL timeout_sticky: err %b owner %b want 1 00",
                     bus.timeout_err, bus.owner);
        end
    endtask

    task automatic test_async_reset();
        logic [147:0] got;
        logic [83:0]  req;
        logic [63:0]  r;
        do_reset();
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 16'h0ABC;
        step();
        #1;
        n_tests++;
        if (bus.owner !== 2'b01) begin
            n_fail++;
            $display("FAIL areset_pre: owner %b want 01", bus.owner);
        end
        #1;
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h7777;
        #1;
        got = {bus.mem_req_valid, bus.owner, bus.i_ready, bus.i_rdata,
               bus.mem_req_addr, bus.mem_req_wdata};
        n_tests++;
        if (got !== 148'h0) begin
            n_fail++;
            $display("FAIL areset_outputs: got %h want 0", got);
        end
        step();
        rst             = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.i_req_addr  = 16'h0DEF;
        step();
        #1;
        req = {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr,
               bus.mem_req_wdata, bus.owner};
        n_tests++;
        if (req !== {1'b1, 1'b0, 16'h0DEF, 64'h0, 2'b01}) begin
            n_fail++;
            $display("FAIL areset_next_req: got %h", req);
        end
        step();
        r = {$urandom, $urandom};
        bus.mem_ready = 1'b1;
        bus.mem_rdata = r;
        #1;
        n_tests++;
        if ({bus.i_ready, bus.i_rdata} !== {1'b1, r}) begin
            n_fail++;
            $display("FAIL areset_next_resp: got %b %h want 1 %h",
                     bus.i_ready, bus.i_rdata, r);
        end
        step();
        idle_inputs();
    endtask

    // Model: each side has at most one pending request; whichever
    // transfer is in flight dictates the memory bus and the response.
    task automatic test_random();
        bit           ip = 0, dp = 0, drw = 0;
        bit           busy = 0, side_d = 0, turn = 0;
        logic [15:0]  ia = '0, da = '0;
        logic [63:0]  dw = '0, rd;
        int           wt = 0, lat = 0, done_i = 0, done_d = 0;
        logic [83:0]  got, exp;
        logic [129:0] rgot, rexp;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!ip && $urandom_range(3) == 0) begin
                ip = 1;
                ia = 16'($urandom);
            end
            if (!dp && $urandom_range(3) == 0) begin
                dp  = 1;
                drw = 1'($urandom);
                da  = 16'($urandom);
                dw  = {$urandom, $urandom};
            end
            bus.i_req_valid = ip;
            bus.i_req_addr  = ia;
            bus.d_req_valid = dp;
            bus.d_req_rw    = drw;
            bus.d_req_addr  = da;
            bus.d_req_wdata = dw;
            rd = {$urandom, $urandom};
            bus.mem_rdata = rd;
            bus.mem_ready = busy ? (lat == 0) : ($urandom_range(3) == 0);
            #1;
            exp = '0;
            if (busy && side_d) exp = {1'b1, drw, da, dw, 2'b10};
            if (busy && !side_d) exp = {1'b1, 1'b0, ia, 64'h0, 2'b01};
            got = {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr,
                   bus.mem_req_wdata, bus.owner};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand_req c=%0d: got %h want %h", c, got, exp);
            end
            rexp = '0;
            if (busy && bus.mem_ready) begin
                rexp = side_d ? {1'b0, 64'h0, 1'b1, rd}
                              : {1'b1, rd, 1'b0, 64'h0};
            end
            rgot = {bus.i_ready, bus.i_rdata, bus.d_ready, bus.d_rdata};
            n_tests++;
            if (rgot !== rexp) begin
                n_fail++;
                $display("FAIL rand_resp c=%0d: got %h want %h", c, rgot, rexp);
            end
            if (busy) begin
                if (ip && side_d && wt < 8) wt++;
                if (bus.mem_ready) begin
                    busy = 0;
                    turn = 1;
                    if (side_d) begin
                        dp = 0;
                        done_d++;
                    end else begin
                        ip = 0;
                        done_i++;
                    end
                end else begin
                    lat--;
                end
            end else if (turn) begin
                turn = 0;
                if (ip && wt < 8) wt++;
            end else if (dp && !(ip && wt >= 8)) begin
                busy   = 1;
                side_d = 1;
                lat    = $urandom_range(4);
                if (ip && wt < 8) wt++;
            end else if (ip) begin
                busy   = 1;
                side_d = 0;
                lat    = $urandom_range(4);
                wt     = 0;
            end
            step();
        end
        n_tests++;
        if (done_i < 10 || done_d < 10 || bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_progress: i %0d d %0d err %b",
                     done_i, done_d, bus.timeout_err);
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_i_fill();
        test_simultaneous();
        test_starvation();
        test_stale_valid();
        test_timeout();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
